// File: rtl/dram_cmd_writer_if.sv
// ----------------------------------------------------------------------------
// dram_cmd_writer_if
// Bundles the two streams around the DRAM command writer:
//   request side : req_valid/req_ready handshake carrying req_op and req_addr
//   command side : cmd_valid/cmd_ready handshake carrying one time-stamped
//                  DDR4 command record (code, bank group, bank, row/column,
//                  cycle stamp)
// Modports:
//   master : the environment around the writer (request queue + logger)
//   slave  : the writer itself
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

interface dram_cmd_writer_if #(
   parameter int ADDR_W = 33
);
   logic              req_valid;
   logic              req_ready;
   logic [1:0]        req_op;
   logic [ADDR_W-1:0] req_addr;

   logic              cmd_valid;
   logic              cmd_ready;
   logic [2:0]        cmd_code;
   logic [1:0]        cmd_bg;
   logic [1:0]        cmd_ba;
   logic [14:0]       cmd_rowcol;
   logic [31:0]       cmd_cycle;

   modport master (
      output req_valid, req_op, req_addr, cmd_ready,
      input  req_ready, cmd_valid, cmd_code, cmd_bg, cmd_ba, cmd_rowcol, cmd_cycle
   );

   modport slave (
      input  req_valid, req_op, req_addr, cmd_ready,
      output req_ready, cmd_valid, cmd_code, cmd_bg, cmd_ba, cmd_rowcol, cmd_cycle
   );
endinterface

// File: rtl/dram_cmd_writer.sv
// ----------------------------------------------------------------------------
// dram_cmd_writer
// Output end of the trace path. Takes one parsed memory request at a time and
// turns it into a closed-page DDR4 command sequence ACT -> RD/WR -> PRE. The
// spacing between commands is enforced by a single down-counting timer, and
// every command leaves as a record stamped with a free-running cycle counter.
// Ports:
//   clk    : single clock
//   rst_n  : asynchronous active-low reset
//   bus    : request stream in, command record stream out (slave modport)
//   busy   : high whenever the FSM is not in IDLE
//   err_op : one-cycle pulse after a request with op 3 has been accepted
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module dram_cmd_writer #(
   parameter int ADDR_W  = 33,
   parameter int T_RCD   = 24,
   parameter int T_RTP   = 12,
   parameter int T_CWL   = 20,
   parameter int T_BURST = 4,
   parameter int T_WR    = 20,
   parameter int T_RP    = 24
) (
   input  logic              clk,
   input  logic              rst_n,
   dram_cmd_writer_if.slave  bus,
   output logic              busy,
   output logic              err_op
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACT,
      S_W_RCD,
      S_RW,
      S_W_PRE,
      S_PRE,
      S_W_RP
   } state_t;

   // A spacing of T cycles is T-1 wait cycles between the two command states.
   // The timer is loaded with T-2 on the issuing handshake and the wait state
   // is left on the cycle it reads zero; a spacing of 1 skips the wait state.
   localparam int          T_WR_SPACE = T_CWL + T_BURST + T_WR;
   localparam logic [15:0] RCD_LD     = 16'((T_RCD > 1) ? (T_RCD - 2) : 0);
   localparam logic [15:0] RTP_LD     = 16'((T_RTP > 1) ? (T_RTP - 2) : 0);
   localparam logic [15:0] WRS_LD     = 16'((T_WR_SPACE > 1) ? (T_WR_SPACE - 2) : 0);
   localparam logic [15:0] RP_LD      = 16'((T_RP > 1) ? (T_RP - 2) : 0);
   localparam logic        RCD_SKIP   = (T_RCD <= 1);
   localparam logic        RTP_SKIP   = (T_RTP <= 1);
   localparam logic        WRS_SKIP   = (T_WR_SPACE <= 1);
   localparam logic        RP_SKIP    = (T_RP <= 1);

   state_t      state_q;
   state_t      state_nx;
   logic [15:0] timer_q;
   logic        timer_ld;
   logic [15:0] timer_ld_val;
   logic [31:0] cycle_cnt;
   logic [31:0] cmd_cycle_q;
   logic [14:0] row_q;
   logic [10:0] col_q;
   logic [1:0]  ba_q;
   logic [1:0]  bg_q;
   logic        is_wr_q;
   logic        err_op_q;
   logic        accept;
   logic        cmd_hs;
   logic        enter_cmd;
   logic        unused_addr_lsb;

   // The low three address bits select a byte within the burst and carry no
   // command information.
   assign unused_addr_lsb = ^bus.req_addr[2:0];

   assign accept = bus.req_valid && (state_q == S_IDLE);
   assign cmd_hs = bus.cmd_valid && bus.cmd_ready;

   // Free-running cycle counter used to stamp every command record; it simply
   // wraps through zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_cnt <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + 32'd1;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_nx;
      end
   end

   // Next-state logic. Each command state waits for the logger handshake and
   // then either arms the timer for the following wait state or, when the
   // spacing is a single cycle, jumps straight to the next command.
   always_comb begin
      state_nx     = state_q;
      timer_ld     = 1'b0;
      timer_ld_val = '0;
      case (state_q)
         S_IDLE: begin
            if (accept && (bus.req_op != 2'd3)) begin
               state_nx = S_ACT;
            end
         end
         S_ACT: begin
            if (bus.cmd_ready) begin
               if (RCD_SKIP) begin
                  state_nx = S_RW;
               end else begin
                  state_nx     = S_W_RCD;
                  timer_ld     = 1'b1;
                  timer_ld_val = RCD_LD;
               end
            end
         end
         S_W_RCD: begin
            if (timer_q == '0) begin
               state_nx = S_RW;
            end
         end
         S_RW: begin
            if (bus.cmd_ready) begin
               if (is_wr_q ? WRS_SKIP : RTP_SKIP) begin
                  state_nx = S_PRE;
               end else begin
                  state_nx     = S_W_PRE;
                  timer_ld     = 1'b1;
                  timer_ld_val = is_wr_q ? WRS_LD : RTP_LD;
               end
            end
         end
         S_W_PRE: begin
            if (timer_q == '0) begin
               state_nx = S_PRE;
            end
         end
         S_PRE: begin
            if (bus.cmd_ready) begin
               if (RP_SKIP) begin
                  state_nx = S_IDLE;
               end else begin
                  state_nx     = S_W_RP;
                  timer_ld     = 1'b1;
                  timer_ld_val = RP_LD;
               end
            end
         end
         S_W_RP: begin
            if (timer_q == '0) begin
               state_nx = S_IDLE;
            end
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // Spacing timer. Loading only on the issuing handshake means a stalled
   // logger can delay a command but never shortens the gap behind it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer_q <= '0;
      end else if (timer_ld) begin
         timer_q <= timer_ld_val;
      end else if (timer_q != '0) begin
         timer_q <= timer_q - 16'd1;
      end
   end

   // Request fields are split out of the address at accept time so the
   // command records stay stable for the whole sequence.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_q   <= '0;
         col_q   <= '0;
         ba_q    <= '0;
         bg_q    <= '0;
         is_wr_q <= 1'b0;
      end else if (accept) begin
         row_q   <= bus.req_addr[ADDR_W-1 -: 15];
         col_q   <= {bus.req_addr[17:10], bus.req_addr[5:3]};
         ba_q    <= bus.req_addr[9:8];
         bg_q    <= bus.req_addr[7:6];
         is_wr_q <= (bus.req_op == 2'd1);
      end
   end

   // The cycle stamp is captured on the edge that first presents a record;
   // the counter takes cycle_cnt+1 on that same edge, so the stamp equals the
   // counter value during the first cycle the record is visible.
   assign enter_cmd = (state_nx != state_q) &&
                      ((state_nx == S_ACT) || (state_nx == S_RW) || (state_nx == S_PRE));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_cycle_q <= '0;
      end else if (enter_cmd) begin
         cmd_cycle_q <= cycle_cnt + 32'd1;
      end
   end

   // Invalid ops are swallowed in IDLE and only flagged by a single pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_op_q <= 1'b0;
      end else begin
         err_op_q <= accept && (bus.req_op == 2'd3);
      end
   end

   // Record fields are driven from the latched request and zeroed whenever no
   // record is on offer, so the stream is quiet outside command states.
   always_comb begin
      bus.cmd_code   = 3'd0;
      bus.cmd_rowcol = '0;
      case (state_q)
         S_ACT: begin
            bus.cmd_code   = 3'd1;
            bus.cmd_rowcol = row_q;
         end
         S_RW: begin
            bus.cmd_code   = is_wr_q ? 3'd3 : 3'd2;
            bus.cmd_rowcol = {4'b0000, col_q};
         end
         S_PRE: begin
            bus.cmd_code   = 3'd4;
         end
         default: begin
            bus.cmd_code   = 3'd0;
         end
      endcase
   end

   assign bus.cmd_valid = (state_q == S_ACT) || (state_q == S_RW) || (state_q == S_PRE);
   assign bus.cmd_bg    = bus.cmd_valid ? bg_q : 2'd0;
   assign bus.cmd_ba    = bus.cmd_valid ? ba_q : 2'd0;
   assign bus.cmd_cycle = bus.cmd_valid ? cmd_cycle_q : 32'd0;
   assign bus.req_ready = (state_q == S_IDLE);
   assign busy          = (state_q != S_IDLE);
   assign err_op        = err_op_q;

   // The in-flight cmd_hs term is kept for readability of the handshake
   // definition; it mirrors the per-state cmd_ready checks above.
   logic unused_cmd_hs;
   assign unused_cmd_hs = cmd_hs;

endmodule
